// File: rtl/bus_pkg.sv
// bus_pkg
// Shared definitions for the register-bus fault-query path: the initiator
// state encoding, default dwell times and the fault counter width.
package bus_pkg;

  typedef enum logic [2:0] {
    I_IDLE    = 3'd0,
    I_ASSERT  = 3'd1,
    I_RELEASE = 3'd2,
    I_SAMPLE  = 3'd3,
    I_DONE    = 3'd4
  } initiator_state_t;

  localparam int BUS_HOLD_CYCLES   = 4;
  localparam int BUS_SAMPLE_DELAY  = 3;
  localparam int BUS_SAMPLE_CYCLES = 2;
  localparam int FAULT_COUNT_WIDTH = 8;
  localparam int DWELL_WIDTH       = 8;

  // A timed state lasting n cycles loads the down-counter with n-1 and
  // leaves when it reads 0.
  function automatic logic [DWELL_WIDTH-1:0] dwell_load(input int n);
    return DWELL_WIDTH'(n - 1);
  endfunction

endpackage

// File: rtl/nfault_synchronizer.sv
// nfault_synchronizer
// Two-flop synchronizer for asynchronous bus inputs. Both stages reset to 1
// because an undriven open-drain bus line idles high.
// Ports:
//   clk       system clock
//   reset     asynchronous, active-low reset
//   async_in  asynchronous input bits
//   sync_out  synchronized copy, two cycles of latency
module nfault_synchronizer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta     <= '1;
      sync_out <= '1;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/bus_fault_initiator.sv
// bus_fault_initiator
// Runs one fault query on the shared register bus: strobes
// bus_register_address_valid, lets responders settle, then samples the
// resolved open-drain nFault line and reports fault / glitch per transaction
// with a saturating fault counter.
// Ports:
//   clk                         system clock
//   reset                       asynchronous, active-low reset
//   start                       one-cycle request, honoured only when idle
//   abort                       cancel the transaction in progress
//   clear_fault_count           synchronous clear of fault_count
//   nFault_in                   resolved bus line (async, high = no fault)
//   bus_register_address_valid  strobe to all subsystems
//   busy                        transaction in progress
//   done                        one-cycle pulse, results valid
//   fault_detected              every sample low in last completed query
//   glitch_detected             mixed samples in last completed query
//   fault_count                 saturating count of faulted queries
//
// state     | meaning
// I_IDLE    | waiting for start
// I_ASSERT  | strobe high for HOLD_CYCLES
// I_RELEASE | strobe low, waiting SAMPLE_DELAY for the line to settle
// I_SAMPLE  | sampling synchronized nFault for SAMPLE_CYCLES
// I_DONE    | results registered, done pulse
module bus_fault_initiator
  import bus_pkg::*;
#(
  parameter int HOLD_CYCLES   = BUS_HOLD_CYCLES,
  parameter int SAMPLE_DELAY  = BUS_SAMPLE_DELAY,
  parameter int SAMPLE_CYCLES = BUS_SAMPLE_CYCLES
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         clear_fault_count,
  input  logic                         nFault_in,
  output logic                         bus_register_address_valid,
  output logic                         busy,
  output logic                         done,
  output logic                         fault_detected,
  output logic                         glitch_detected,
  output logic [FAULT_COUNT_WIDTH-1:0] fault_count
);

  localparam logic [DWELL_WIDTH-1:0] HOLD_LOAD   = dwell_load(HOLD_CYCLES);
  localparam logic [DWELL_WIDTH-1:0] DELAY_LOAD  = dwell_load(SAMPLE_DELAY);
  localparam logic [DWELL_WIDTH-1:0] SAMPLE_LOAD = dwell_load(SAMPLE_CYCLES);

  initiator_state_t state, state_next;
  logic [DWELL_WIDTH-1:0] dwell, dwell_load_val;
  logic dwell_load_en;
  logic sample_clear;
  logic result_en;
  logic nfault_sync;
  logic seen_low, seen_high;
  logic low_next, high_next;
  logic fault_now;

  nfault_synchronizer #(.WIDTH(1)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (nFault_in),
    .sync_out (nfault_sync)
  );

  // Flags including the current sample, so the final sample cycle can feed
  // the result registers directly.
  assign low_next  = seen_low  | ~nfault_sync;
  assign high_next = seen_high |  nfault_sync;
  assign fault_now = low_next & ~high_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= I_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next     = state;
    dwell_load_en  = 1'b0;
    dwell_load_val = '0;
    sample_clear   = 1'b0;
    result_en      = 1'b0;
    case (state)
      I_IDLE: begin
        if (start) begin
          state_next     = I_ASSERT;
          dwell_load_en  = 1'b1;
          dwell_load_val = HOLD_LOAD;
        end
      end
      I_ASSERT: begin
        if (dwell == '0) begin
          state_next     = I_RELEASE;
          dwell_load_en  = 1'b1;
          dwell_load_val = DELAY_LOAD;
        end
      end
      I_RELEASE: begin
        if (dwell == '0) begin
          state_next     = I_SAMPLE;
          dwell_load_en  = 1'b1;
          dwell_load_val = SAMPLE_LOAD;
          sample_clear   = 1'b1;
        end
      end
      I_SAMPLE: begin
        if (dwell == '0) begin
          state_next = I_DONE;
          result_en  = 1'b1;
        end
      end
      I_DONE:  state_next = I_IDLE;
      default: state_next = I_IDLE;
    endcase
    // Abort overrides everything except an idle start.
    if (abort && (state != I_IDLE)) begin
      state_next    = I_IDLE;
      dwell_load_en = 1'b0;
      sample_clear  = 1'b0;
      result_en     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              dwell <= '0;
    else if (dwell_load_en)  dwell <= dwell_load_val;
    else if (dwell != '0)    dwell <= dwell - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seen_low  <= 1'b0;
      seen_high <= 1'b0;
    end else if (sample_clear) begin
      seen_low  <= 1'b0;
      seen_high <= 1'b0;
    end else if (state == I_SAMPLE) begin
      seen_low  <= low_next;
      seen_high <= high_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault_detected  <= 1'b0;
      glitch_detected <= 1'b0;
    end else if (result_en) begin
      fault_detected  <= fault_now;
      glitch_detected <= low_next & high_next;
    end
  end

  // Clear has priority over a coincident increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      fault_count <= '0;
    else if (clear_fault_count)
      fault_count <= '0;
    else if (result_en && fault_now && (fault_count != '1))
      fault_count <= fault_count + 1'b1;
  end

  assign bus_register_address_valid = (state == I_ASSERT);
  assign busy                       = (state != I_IDLE);
  assign done                       = (state == I_DONE);

endmodule

// File: tb/tb_bus_fault_initiator.sv
// tb_bus_fault_initiator
// Directed bench for bus_fault_initiator with default parameters.
// Cycle n is the clock period ending at rising edge n; start is high in
// cycle 0, the strobe is high in cycles 1..4, samples land in cycles 8..9
// and done is high in cycle 10. Inputs change and outputs are sampled 1 ns
// after a rising edge.
module tb_bus_fault_initiator;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic       clear_fault_count;
  logic       nFault_in;
  logic       valid;
  logic       busy;
  logic       done;
  logic       fault_detected;
  logic       glitch_detected;
  logic [7:0] fault_count;

  int n_total = 0;
  int n_pass  = 0;

  bus_fault_initiator dut (
    .clk                        (clk),
    .reset                      (reset),
    .start                      (start),
    .abort                      (abort),
    .clear_fault_count          (clear_fault_count),
    .nFault_in                  (nFault_in),
    .bus_register_address_valid (valid),
    .busy                       (busy),
    .done                       (done),
    .fault_detected             (fault_detected),
    .glitch_detected            (glitch_detected),
    .fault_count                (fault_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lo_from;   // first cycle the raw line is low (0 = never)
    int lo_to;     // first cycle it is high again
    bit clr;       // clear during the increment cycle
    bit exp_fault;
    bit exp_glitch;
    int exp_count;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_results(input string tag, input bit f, input bit g, input int c);
    check({tag, " fault_detected"}, int'(fault_detected), int'(f));
    check({tag, " glitch_detected"}, int'(glitch_detected), int'(g));
    check({tag, " fault_count"}, int'(fault_count), c);
  endtask

  // Entered in an idle cycle (cycle 0); returns in cycle 11, idle again.
  task automatic run_txn(input int lo_from, input int lo_to, input bit clr,
                         input bit pulse_start, input bit chk_on);
    start     = 1'b1;
    nFault_in = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      start             = pulse_start && (k <= 9);
      nFault_in         = (k >= lo_from && k < lo_to) ? 1'b0 : 1'b1;
      clear_fault_count = clr && (k == 9);
      if (chk_on) begin
        check($sformatf("strobe c%0d", k), int'(valid), int'(k <= 4));
        check($sformatf("busy c%0d", k), int'(busy), 1);
        check($sformatf("done c%0d", k), int'(done), int'(k == 10));
      end
    end
    cyc();
    start = 1'b0;
    if (chk_on) begin
      check("idle after done busy", int'(busy), 0);
      check("idle after done done", int'(done), 0);
    end
  endtask

  initial begin
    // Line low from cycle 5 reaches the sampler from cycle 7: both samples low.
    // A raw low in cycle 6 only shows up synchronized in cycle 8 (first
    // sample only); a raw low in cycle 7 only hits the second sample.
    vecs[0] = '{0, 0,   1'b0, 1'b0, 1'b0, 0};
    vecs[1] = '{5, 100, 1'b0, 1'b1, 1'b0, 1};
    vecs[2] = '{6, 7,   1'b0, 1'b0, 1'b1, 1};
    vecs[3] = '{7, 8,   1'b0, 1'b0, 1'b1, 1};
    for (int i = 4; i < 13; i++) vecs[i] = '{5, 100, 1'b0, 1'b1, 1'b0, i - 2};

    reset = 1'b0; start = 1'b0; abort = 1'b0;
    clear_fault_count = 1'b0; nFault_in = 1'b1;
    #1;
    check("reset strobe", int'(valid), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check_results("reset", 1'b0, 1'b0, 0);
    cyc(); cyc();
    reset = 1'b1;
    cyc();

    for (int i = 0; i < 13; i++) begin
      run_txn(vecs[i].lo_from, vecs[i].lo_to, vecs[i].clr, 1'b0, 1'b1);
      check_results($sformatf("vec%0d", i), vecs[i].exp_fault, vecs[i].exp_glitch,
                    vecs[i].exp_count);
    end

    // Saturation: 245 more faults bring the count to 255, one more holds it.
    for (int i = 0; i < 245; i++) run_txn(5, 100, 1'b0, 1'b0, 1'b0);
    check_results("reach 255", 1'b1, 1'b0, 255);
    run_txn(5, 100, 1'b0, 1'b0, 1'b1);
    check_results("saturate", 1'b1, 1'b0, 255);

    // Clear coinciding with an increment wins.
    run_txn(5, 100, 1'b1, 1'b0, 1'b1);
    check_results("clear vs incr", 1'b1, 1'b0, 0);
    run_txn(5, 100, 1'b0, 1'b0, 1'b1);
    check_results("count after clear", 1'b1, 1'b0, 1);

    // Abort in cycle 3: strobe gone in cycle 4, no done, results retained.
    start = 1'b1; nFault_in = 1'b1;
    cyc(); start = 1'b0;
    cyc(); cyc();
    check("abort pre strobe", int'(valid), 1);
    abort = 1'b1;
    cyc(); abort = 1'b0;
    check("abort strobe", int'(valid), 0);
    check("abort busy", int'(busy), 0);
    begin
      int done_seen = 0;
      for (int k = 0; k < 10; k++) begin
        if (done) done_seen++;
        cyc();
      end
      check("abort no done", done_seen, 0);
    end
    check_results("abort retain", 1'b1, 1'b0, 1);

    // start and abort together while idle: the transaction starts.
    start = 1'b1; abort = 1'b1;
    cyc(); start = 1'b0;
    check("start+abort busy", int'(busy), 1);
    check("start+abort strobe", int'(valid), 1);
    cyc(); abort = 1'b0;
    check("abort c1 busy", int'(busy), 0);
    cyc();

    // start pulses during a transaction are neither honoured nor queued.
    run_txn(0, 0, 1'b0, 1'b1, 1'b1);
    check_results("ignored starts", 1'b0, 1'b0, 1);
    check("no queued start", int'(busy), 0);
    cyc();
    check("no queued start later", int'(busy), 0);

    // Reset in cycle 6 of a faulting transaction.
    run_txn(5, 100, 1'b0, 1'b0, 1'b1);
    check_results("pre reset", 1'b1, 1'b0, 2);
    start = 1'b1; nFault_in = 1'b1;
    cyc(); start = 1'b0;
    for (int k = 2; k <= 6; k++) cyc();
    check("pre reset busy", int'(busy), 1);
    reset = 1'b0;
    #1;
    check("mid reset strobe", int'(valid), 0);
    check("mid reset busy", int'(busy), 0);
    check("mid reset done", int'(done), 0);
    check_results("mid reset", 1'b0, 1'b0, 0);
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    run_txn(0, 0, 1'b0, 1'b0, 1'b1);
    check_results("after reset", 1'b0, 1'b0, 0);
    run_txn(5, 100, 1'b0, 1'b0, 1'b1);
    check_results("after reset fault", 1'b1, 1'b0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
